// File: rtl/axi_write_arbiter.sv
// Two-master, three-slave AXI write-channel arbiter: round-robin grant,
// address decode to S0/S1/DECERR slave, and burst-length checking on WLAST.
//
// state | meaning
// ------+---------------------------------------------------------------
// ADDR  | arbitrate, then hold the grant until the AW handshake
// DATA  | count W beats of the granted master until its WLAST handshake
// RESP  | wait for the selected slave's B handshake, then release grant
module axi_write_arbiter (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic        AWVALID_M0,
    input  logic        AWVALID_M1,
    input  logic [31:0] AWADDR_M0,
    input  logic [31:0] AWADDR_M1,
    input  logic [3:0]  AWLEN_M0,
    input  logic [3:0]  AWLEN_M1,
    input  logic        AWREADY_S0,
    input  logic        AWREADY_S1,
    input  logic        AWREADY_SD,
    input  logic        WVALID_M0,
    input  logic        WVALID_M1,
    input  logic        WLAST_M0,
    input  logic        WLAST_M1,
    input  logic        WREADY_S0,
    input  logic        WREADY_S1,
    input  logic        WREADY_SD,
    input  logic        BVALID_S0,
    input  logic        BVALID_S1,
    input  logic        BVALID_SD,
    input  logic        BREADY_M0,
    input  logic        BREADY_M1,
    output logic [1:0]  Write_State_control,
    output logic [3:0]  Arbiter_AWID_control,
    output logic        wr_len_err
);

    typedef enum logic [1:0] {
        ST_ADDR = 2'b00,
        ST_DATA = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic        gnt_vld_q, gnt_vld_d;
    logic        gnt_m_q, gnt_m_d;
    logic [2:0]  slv_q, slv_d;
    logic [3:0]  len_q, len_d;
    logic        ptr_q, ptr_d;
    logic [4:0]  beat_q, beat_d;
    logic        len_err_q, len_err_d;

    logic        pick_m;
    logic        aw_hs, w_hs, b_hs;
    logic        w_last_g;
    logic [4:0]  beat_inc;
    logic [4:0]  beats_exp;

    // Only the upper address half takes part in slave decode.
    logic        unused_addr_bits;
    assign unused_addr_bits = ^{AWADDR_M0[15:0], AWADDR_M1[15:0]};

    function automatic logic [2:0] decode_slave(input logic [31:0] addr);
        logic [2:0] sel;
        case (addr[31:16])
            16'h0000: sel = 3'b001;
            16'h0001: sel = 3'b010;
            default:  sel = 3'b100;
        endcase
        return sel;
    endfunction

    // ptr_q = 0 favours M0 on contention; a lone requester always wins.
    assign pick_m = (AWVALID_M0 && AWVALID_M1) ? ptr_q : AWVALID_M1;

    assign aw_hs = gnt_vld_q
                 && (gnt_m_q ? AWVALID_M1 : AWVALID_M0)
                 && |(slv_q & {AWREADY_SD, AWREADY_S1, AWREADY_S0});
    assign w_hs  = gnt_vld_q
                 && (gnt_m_q ? WVALID_M1 : WVALID_M0)
                 && |(slv_q & {WREADY_SD, WREADY_S1, WREADY_S0});
    assign b_hs  = gnt_vld_q
                 && (gnt_m_q ? BREADY_M1 : BREADY_M0)
                 && |(slv_q & {BVALID_SD, BVALID_S1, BVALID_S0});

    assign w_last_g  = gnt_m_q ? WLAST_M1 : WLAST_M0;
    assign beat_inc  = beat_q + 5'd1;
    assign beats_exp = {1'b0, len_q} + 5'd1;

    always_comb begin
        state_d   = state_q;
        gnt_vld_d = gnt_vld_q;
        gnt_m_d   = gnt_m_q;
        slv_d     = slv_q;
        len_d     = len_q;
        ptr_d     = ptr_q;
        beat_d    = beat_q;
        len_err_d = 1'b0;

        case (state_q)
            ST_ADDR: begin
                if (!gnt_vld_q) begin
                    if (AWVALID_M0 || AWVALID_M1) begin
                        gnt_vld_d = 1'b1;
                        gnt_m_d   = pick_m;
                        slv_d     = decode_slave(pick_m ? AWADDR_M1 : AWADDR_M0);
                        len_d     = pick_m ? AWLEN_M1 : AWLEN_M0;
                    end
                end else if (aw_hs) begin
                    state_d = ST_DATA;
                    beat_d  = 5'd0;
                end
            end
            ST_DATA: begin
                if (w_hs) begin
                    beat_d = beat_inc;
                    // WLAST ends the burst whatever the count; a short or long burst is flagged.
                    if (w_last_g) begin
                        state_d   = ST_RESP;
                        len_err_d = (beat_inc != beats_exp);
                    end
                end
            end
            ST_RESP: begin
                if (b_hs) begin
                    state_d   = ST_ADDR;
                    gnt_vld_d = 1'b0;
                    gnt_m_d   = 1'b0;
                    slv_d     = 3'b000;
                    ptr_d     = ~gnt_m_q;
                end
            end
            default: begin
                state_d   = ST_ADDR;
                gnt_vld_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= ST_ADDR;
            gnt_vld_q <= 1'b0;
            gnt_m_q   <= 1'b0;
            slv_q     <= 3'b000;
            len_q     <= 4'd0;
            ptr_q     <= 1'b0;
            beat_q    <= 5'd0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_vld_q <= gnt_vld_d;
            gnt_m_q   <= gnt_m_d;
            slv_q     <= slv_d;
            len_q     <= len_d;
            ptr_q     <= ptr_d;
            beat_q    <= beat_d;
            len_err_q <= len_err_d;
        end
    end

    assign Write_State_control  = state_q;
    assign Arbiter_AWID_control = gnt_vld_q ? {gnt_m_q, slv_q} : 4'b0000;
    assign wr_len_err           = len_err_q;

endmodule
